// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD digit constants, digit type and nibble validity helper.
// Imported by the digit slice and by the counter top.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic is_bcd(input bcd_digit_t nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One decimal digit register: clear > load > step, with wrap at 9/0 inside the digit.
// Latency: one clock per update. Backpressure: none, steps whenever step_in is high.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       load,
    input  bcd_digit_t load_dat,
    input  logic       step_in,
    input  logic       up_dn,
    output bcd_digit_t digit,
    output logic       at_max,
    output logic       at_min
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = BCD_MIN;
        end else if (load) begin
            digit_d = load_dat;
        end else if (step_in) begin
            if (up_dn) begin
                digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign at_max = (digit_q == BCD_MAX);
    assign at_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, validated load, wrap/saturate and carry chain.
// Latency: count and pulses update one clock after the sampled edge; carry_out is zero-latency.
// Backpressure: none; enable is the only flow control and carry_out feeds a downstream enable.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    enable,
    input  logic                    up_dn,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    carry_out,
    output logic                    limit_hit,
    output logic                    load_err
);

    logic [NUM_DIGITS:0]   chain;
    logic [NUM_DIGITS-1:0] step;
    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] at_min;
    bcd_digit_t            digits [NUM_DIGITS];

    logic load_ok;
    logic load_acc;
    logic at_limit;
    logic hold;

    logic limit_hit_q, limit_hit_d;
    logic load_err_q,  load_err_d;

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd(load_value[4*i +: 4])) begin
                load_ok = 1'b0;
            end
        end
    end

    // A rejected load still outranks enable, so the step chain is gated by load, not load_acc.
    assign chain[0] = enable & ~clear & ~load;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            assign chain[g+1] = chain[g] & (up_dn ? at_max[g] : at_min[g]);
            assign step[g]    = chain[g] & ~hold;

            bcd_digit u_digit (
                .clk      (clk),
                .reset_n  (reset_n),
                .clear    (clear),
                .load     (load_acc),
                .load_dat (load_value[4*g +: 4]),
                .step_in  (step[g]),
                .up_dn    (up_dn),
                .digit    (digits[g]),
                .at_max   (at_max[g]),
                .at_min   (at_min[g])
            );

            assign count[4*g +: 4] = digits[g];
        end
    endgenerate

    assign at_limit  = chain[NUM_DIGITS];
    assign hold      = SATURATE && at_limit;
    assign load_acc  = load & load_ok;
    assign carry_out = at_limit;

    always_comb begin
        limit_hit_d = at_limit;
        load_err_d  = ~clear & load & ~load_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            limit_hit_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            limit_hit_q <= limit_hit_d;
            load_err_q  <= load_err_d;
        end
    end

    assign limit_hit = limit_hit_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: wrap and saturate counters side by side, plus a two-stage cascade.
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        clear, load, enable, up_dn;
    logic [15:0] load_value;

    logic [15:0] cnt_w, cnt_s;
    logic        co_w, lh_w, le_w, co_s, lh_s, le_s;

    logic        cen;
    logic        tie0;
    logic [7:0]  lo_cnt, hi_cnt, lo_zero;
    logic        lo_co, lo_lh, lo_le, hi_co, hi_lh, hi_le;
    logic [15:0] ref_cnt, ref_zero;
    logic        ref_co, ref_lh, ref_le;

    int checks = 0;
    int errors = 0;

    bcd_updown_counter #(.NUM_DIGITS(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_dn(up_dn), .count(cnt_w), .carry_out(co_w),
        .limit_hit(lh_w), .load_err(le_w));

    bcd_updown_counter #(.NUM_DIGITS(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_dn(up_dn), .count(cnt_s), .carry_out(co_s),
        .limit_hit(lh_s), .load_err(le_s));

    bcd_updown_counter #(.NUM_DIGITS(2), .SATURATE(1'b0)) u_lo (
        .clk(clk), .reset_n(reset_n), .clear(tie0), .load(tie0), .load_value(lo_zero),
        .enable(cen), .up_dn(1'b1), .count(lo_cnt), .carry_out(lo_co),
        .limit_hit(lo_lh), .load_err(lo_le));

    bcd_updown_counter #(.NUM_DIGITS(2), .SATURATE(1'b0)) u_hi (
        .clk(clk), .reset_n(reset_n), .clear(tie0), .load(tie0), .load_value(lo_zero),
        .enable(lo_co), .up_dn(1'b1), .count(hi_cnt), .carry_out(hi_co),
        .limit_hit(hi_lh), .load_err(hi_le));

    bcd_updown_counter #(.NUM_DIGITS(4), .SATURATE(1'b0)) u_ref (
        .clk(clk), .reset_n(reset_n), .clear(tie0), .load(tie0), .load_value(ref_zero),
        .enable(cen), .up_dn(1'b1), .count(ref_cnt), .carry_out(ref_co),
        .limit_hit(ref_lh), .load_err(ref_le));

    function automatic int bcd2int(input logic [15:0] b);
        int v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit all_bcd(input logic [15:0] b);
        for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Decimal-integer reference: next count value and the two pulse expectations.
    function automatic void model_next(input int cur, input bit c, input bit l, input bit e,
                                       input bit u, input logic [15:0] v, input bit sat,
                                       output int nv, output bit lh, output bit le);
        nv = cur; lh = 1'b0; le = 1'b0;
        if (c) nv = 0;
        else if (l) begin
            if (all_bcd(v)) nv = bcd2int(v);
            else le = 1'b1;
        end else if (e) begin
            if (u) begin
                if (cur == 9999) begin lh = 1'b1; nv = sat ? 9999 : 0; end
                else nv = cur + 1;
            end else begin
                if (cur == 0) begin lh = 1'b1; nv = sat ? 0 : 9999; end
                else nv = cur - 1;
            end
        end
    endfunction

    task automatic set_in(input logic c, input logic l, input logic e, input logic u,
                          input logic [15:0] v);
        clear = c; load = l; enable = e; up_dn = u; load_value = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 16'h0000);
        #1;
        checks++; if (cnt_w !== 16'h0000 || cnt_s !== 16'h0000) begin errors++; $display("FAIL reset_initial: got %h/%h expected 0000", cnt_w, cnt_s); end
        @(negedge clk); reset_n = 1'b1;
        tick();
        set_in(0, 1, 0, 0, 16'h1234); tick();
        checks++; if (cnt_w !== 16'h1234) begin errors++; $display("FAIL reset_preload: got %h expected 1234", cnt_w); end
        set_in(0, 1, 0, 0, 16'hF000); tick();
        checks++; if (le_w !== 1'b1 || cnt_w !== 16'h1234) begin errors++; $display("FAIL reset_prepulse: le=%b cnt=%h expected 1/1234", le_w, cnt_w); end
        set_in(0, 0, 0, 0, 16'h0000);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (cnt_w !== 16'h0000 || cnt_s !== 16'h0000) begin errors++; $display("FAIL reset_async_count: got %h/%h expected 0000", cnt_w, cnt_s); end
        checks++; if ({lh_w, le_w, lh_s, le_s} !== 4'b0000) begin errors++; $display("FAIL reset_async_pulses: got %b expected 0000", {lh_w, le_w, lh_s, le_s}); end
        @(negedge clk); reset_n = 1'b1;
        tick();
        checks++; if (cnt_w !== 16'h0000 || le_w !== 1'b0) begin errors++; $display("FAIL reset_after: cnt=%h le=%b expected 0000/0", cnt_w, le_w); end
    endtask

    task automatic test_up_ripple();
        set_in(0, 1, 0, 0, 16'h0999); tick();
        set_in(0, 0, 1, 1, 16'h0000); #1;
        checks++; if (co_w !== 1'b0) begin errors++; $display("FAIL up_carry_low: got %b expected 0", co_w); end
        tick();
        checks++; if (cnt_w !== 16'h1000 || lh_w !== 1'b0) begin errors++; $display("FAIL up_ripple: cnt=%h lh=%b expected 1000/0", cnt_w, lh_w); end
        set_in(0, 1, 0, 0, 16'h9999); tick();
        set_in(0, 0, 1, 1, 16'h0000); #1;
        checks++; if (co_w !== 1'b1 || co_s !== 1'b1) begin errors++; $display("FAIL up_carry_max: got %b/%b expected 1/1", co_w, co_s); end
        tick();
        checks++; if (cnt_w !== 16'h0000 || lh_w !== 1'b1) begin errors++; $display("FAIL up_wrap: cnt=%h lh=%b expected 0000/1", cnt_w, lh_w); end
        #1;
        checks++; if (co_w !== 1'b0) begin errors++; $display("FAIL up_carry_after: got %b expected 0", co_w); end
        tick();
        checks++; if (cnt_w !== 16'h0001 || lh_w !== 1'b0) begin errors++; $display("FAIL up_after_wrap: cnt=%h lh=%b expected 0001/0", cnt_w, lh_w); end
    endtask

    task automatic test_down_borrow();
        set_in(0, 1, 0, 0, 16'h1000); tick();
        set_in(0, 0, 1, 0, 16'h0000); #1;
        checks++; if (co_w !== 1'b0) begin errors++; $display("FAIL down_carry_low: got %b expected 0", co_w); end
        tick();
        checks++; if (cnt_w !== 16'h0999 || lh_w !== 1'b0) begin errors++; $display("FAIL down_borrow: cnt=%h lh=%b expected 0999/0", cnt_w, lh_w); end
        set_in(0, 1, 0, 0, 16'h0000); tick();
        set_in(0, 0, 1, 0, 16'h0000); #1;
        checks++; if (co_w !== 1'b1 || co_s !== 1'b1) begin errors++; $display("FAIL down_carry_min: got %b/%b expected 1/1", co_w, co_s); end
        tick();
        checks++; if (cnt_w !== 16'h9999 || lh_w !== 1'b1) begin errors++; $display("FAIL down_wrap: cnt=%h lh=%b expected 9999/1", cnt_w, lh_w); end
        checks++; if (cnt_s !== 16'h0000 || lh_s !== 1'b1) begin errors++; $display("FAIL down_sat: cnt=%h lh=%b expected 0000/1", cnt_s, lh_s); end
    endtask

    task automatic test_saturate();
        set_in(0, 1, 0, 0, 16'h9999); tick();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 1, 1, 16'h0000); tick();
            checks++; if (cnt_s !== 16'h9999 || lh_s !== 1'b1) begin errors++; $display("FAIL sat_up_%0d: cnt=%h lh=%b expected 9999/1", k, cnt_s, lh_s); end
            checks++; if (cnt_w !== int2bcd(k) || lh_w !== (k == 0)) begin errors++; $display("FAIL sat_wrapref_%0d: cnt=%h lh=%b expected %h/%0d", k, cnt_w, lh_w, int2bcd(k), k == 0); end
        end
        set_in(0, 1, 0, 0, 16'h0000); tick();
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 1, 0, 16'h0000); tick();
            checks++; if (cnt_s !== 16'h0000 || lh_s !== 1'b1) begin errors++; $display("FAIL sat_down_%0d: cnt=%h lh=%b expected 0000/1", k, cnt_s, lh_s); end
        end
        set_in(0, 0, 0, 0, 16'h0000); tick();
        checks++; if (lh_s !== 1'b0) begin errors++; $display("FAIL sat_pulse_end: got %b expected 0", lh_s); end
    endtask

    task automatic test_load_check();
        set_in(0, 1, 0, 0, 16'h4321); tick();
        checks++; if (cnt_w !== 16'h4321 || le_w !== 1'b0) begin errors++; $display("FAIL load_valid: cnt=%h le=%b expected 4321/0", cnt_w, le_w); end
        set_in(0, 1, 1, 1, 16'h12A4); tick();
        checks++; if (cnt_w !== 16'h4321 || le_w !== 1'b1 || le_s !== 1'b1) begin errors++; $display("FAIL load_reject: cnt=%h le=%b/%b expected 4321/1/1", cnt_w, le_w, le_s); end
        set_in(0, 0, 0, 0, 16'h0000); tick();
        checks++; if (le_w !== 1'b0 || cnt_w !== 16'h4321) begin errors++; $display("FAIL load_err_end: le=%b cnt=%h expected 0/4321", le_w, cnt_w); end
        set_in(1, 1, 1, 1, 16'h5555); tick();
        checks++; if (cnt_w !== 16'h0000 || cnt_s !== 16'h0000) begin errors++; $display("FAIL clear_prio: got %h/%h expected 0000", cnt_w, cnt_s); end
        set_in(0, 1, 1, 1, 16'h0500); #1;
        checks++; if (co_w !== 1'b0) begin errors++; $display("FAIL load_carry: got %b expected 0", co_w); end
        tick();
        checks++; if (cnt_w !== 16'h0500) begin errors++; $display("FAIL load_over_enable: got %h expected 0500", cnt_w); end
        set_in(0, 1, 0, 0, 16'h9999); tick();
        set_in(0, 1, 1, 1, 16'h9999); #1;
        checks++; if (co_w !== 1'b0) begin errors++; $display("FAIL load_carry_max: got %b expected 0", co_w); end
        tick();
        checks++; if (cnt_w !== 16'h9999 || lh_w !== 1'b0) begin errors++; $display("FAIL load_at_max: cnt=%h lh=%b expected 9999/0", cnt_w, lh_w); end
    endtask

    task automatic test_random();
        int rw = 0, rs = 0, nw, ns;
        bit c, l, e, u, lhw, lhs, lew, les, cw, cs;
        logic [15:0] v;
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 19) == 0) || (i == 0);
            l = ($urandom_range(0, 6) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: v = 16'h9999;
                1: v = 16'h0000;
                2: v = 16'h9998;
                3: v = 16'h0001;
                4: v = 16'($urandom);
                default: v = int2bcd($urandom_range(0, 9999));
            endcase
            set_in(c, l, e, u, v); #1;
            cw = e && !c && !l && (u ? (rw == 9999) : (rw == 0));
            cs = e && !c && !l && (u ? (rs == 9999) : (rs == 0));
            checks++; if (co_w !== cw || co_s !== cs) begin errors++; $display("FAIL rand_carry[%0d]: got %b/%b expected %b/%b", i, co_w, co_s, cw, cs); end
            model_next(rw, c, l, e, u, v, 1'b0, nw, lhw, lew);
            model_next(rs, c, l, e, u, v, 1'b1, ns, lhs, les);
            rw = nw; rs = ns;
            tick();
            checks++; if (cnt_w !== int2bcd(rw) || lh_w !== lhw || le_w !== lew) begin errors++; $display("FAIL rand_wrap[%0d]: cnt=%h lh=%b le=%b expected %h/%b/%b", i, cnt_w, lh_w, le_w, int2bcd(rw), lhw, lew); end
            checks++; if (cnt_s !== int2bcd(rs) || lh_s !== lhs || le_s !== les) begin errors++; $display("FAIL rand_sat[%0d]: cnt=%h lh=%b le=%b expected %h/%b/%b", i, cnt_s, lh_s, le_s, int2bcd(rs), lhs, les); end
        end
        set_in(0, 0, 0, 0, 16'h0000);
    endtask

    task automatic test_cascade();
        int c = 0;
        checks++; if ({hi_cnt, lo_cnt} !== 16'h0000 || ref_cnt !== 16'h0000) begin errors++; $display("FAIL cascade_start: got %h/%h expected 0000", {hi_cnt, lo_cnt}, ref_cnt); end
        cen = 1'b1;
        for (int i = 0; i < 10001; i++) begin
            tick();
            c = (c + 1) % 10000;
            checks++; if ({hi_cnt, lo_cnt} !== ref_cnt) begin errors++; $display("FAIL cascade_match[%0d]: got %h expected %h", i, {hi_cnt, lo_cnt}, ref_cnt); end
            checks++; if (ref_cnt !== int2bcd(c)) begin errors++; $display("FAIL cascade_value[%0d]: got %h expected %h", i, ref_cnt, int2bcd(c)); end
        end
        cen = 1'b0;
    endtask

    initial begin
        tie0 = 1'b0; cen = 1'b0; lo_zero = 8'h00; ref_zero = 16'h0000;
        test_reset();
        test_up_ripple();
        test_down_borrow();
        test_saturate();
        test_load_check();
        test_random();
        test_cascade();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
